ham_dec_pipe: RTL and testbench

//   Pipelined Hamming(17,12) single-error-correcting decoder. It consumes codewords from the

---
 rtl/ham_pkg.sv | 21 ++
 rtl/ham_syndrome_calc.sv | 16 +
 rtl/ham_dec_pipe.sv | 133 +++++++++++++
 tb/tb_ham_dec_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared Hamming(17,12) constants: sizes, parity/info index maps, syndrome type
// and the info-extraction helper used by the encoder and decoder paths.
package ham_pkg;
  localparam int HAM_K = 12;
  localparam int HAM_N = 17;
  localparam int HAM_R = 5;

  typedef logic [HAM_R-1:0] syn_t;

  localparam int PAR_IDX  [HAM_R] = '{0, 1, 3, 7, 15};
  localparam int INFO_IDX [HAM_K] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16};

  function automatic logic [HAM_K-1:0] extract_info(input logic [HAM_N-1:0] cw);
    logic [HAM_K-1:0] info;
    info = '0;
    for (int i = 0; i < HAM_K; i++) begin
      info[i] = cw[INFO_IDX[i]];
    end
    return info;
  endfunction
endpackage

// File: rtl/ham_syndrome_calc.sv
// Combinational Hamming(17,12) syndrome: XOR of the 1-based positions of all set bits.
module ham_syndrome_calc
  import ham_pkg::*;
(
  input  logic [16:0] codeword,
  output logic [4:0]  syndrome
);

  always_comb begin
    syndrome = '0;
    for (int i = 0; i < HAM_N; i++) begin
      if (codeword[i]) syndrome = syndrome ^ syn_t'(i + 1);
    end
  end

endmodule

// File: rtl/ham_dec_pipe.sv
// Two-stage pipelined Hamming(17,12) SEC decoder with valid/ready on both sides.
// Optional saturating error counters are built when HAM_DEC_ERRCNT_EN is defined.
module ham_dec_pipe
  import ham_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      info_out,
  output logic             err_corr,
`ifdef HAM_DEC_ERRCNT_EN
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  input  logic             cnt_clr,
`endif
  output logic             err_uncorr
);

  logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic             adv_p1, adv_p2;
  logic [HAM_N-1:0] cw_p1_q, cw_p1_d;
  syn_t             syn_p1_q, syn_p1_d;
  logic [HAM_R-1:0] syn_in;
  logic [HAM_K-1:0] info_p2_q, info_p2_d;
  logic             corr_p2_q, corr_p2_d, uncorr_p2_q, uncorr_p2_d;
  logic             corr_s, uncorr_s;
  logic [HAM_N-1:0] flip_s;

  ham_syndrome_calc u_syn (
    .codeword (codeword_in),
    .syndrome (syn_in)
  );

  always_comb begin
    adv_p2   = !vld_p2_q || out_ready;
    adv_p1   = !vld_p1_q || adv_p2;
    vld_p1_d = adv_p1 ? in_valid : vld_p1_q;
    vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;

    // Stage 0 -> 1: capture codeword and its syndrome
    cw_p1_d  = cw_p1_q;
    syn_p1_d = syn_p1_q;
    if (adv_p1 && in_valid) begin
      cw_p1_d  = codeword_in;
      syn_p1_d = syn_in;
    end

    // Stage 1 -> 2: correct the addressed bit, extract info, raise flags
    corr_s   = (syn_p1_q != '0) && (syn_p1_q <= syn_t'(HAM_N));
    uncorr_s = (syn_p1_q > syn_t'(HAM_N));
    flip_s   = corr_s ? (HAM_N'(1) << (syn_p1_q - syn_t'(1))) : '0;

    info_p2_d   = info_p2_q;
    corr_p2_d   = corr_p2_q;
    uncorr_p2_d = uncorr_p2_q;
    if (adv_p2 && vld_p1_q) begin
      info_p2_d   = extract_info(cw_p1_q ^ flip_s);
      corr_p2_d   = corr_s;
      uncorr_p2_d = uncorr_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    cw_p1_q     <= cw_p1_d;
    syn_p1_q    <= syn_p1_d;
    info_p2_q   <= info_p2_d;
    corr_p2_q   <= corr_p2_d;
    uncorr_p2_q <= uncorr_p2_d;
  end

  // Data registers are never reset; outputs read as zero while nothing is valid.
  assign in_ready   = adv_p1;
  assign out_valid  = vld_p2_q;
  assign info_out   = vld_p2_q ? info_p2_q : '0;
  assign err_corr   = vld_p2_q & corr_p2_q;
  assign err_uncorr = vld_p2_q & uncorr_p2_q;

`ifdef HAM_DEC_ERRCNT_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
  logic             fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    fire         = vld_p2_q && out_ready;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (fire) begin
      if (corr_p2_q)   corr_cnt_d   = sat_inc(corr_cnt_q);
      if (uncorr_p2_q) uncorr_cnt_d = sat_inc(uncorr_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  // CNT_W only sizes the counters; keep it referenced when they are not built.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ham_dec_pipe.sv
// Scoreboard bench for ham_dec_pipe: directed syndrome cases, stall/backpressure,
// mid-stream reset, optional counters (HAM_DEC_ERRCNT_EN) and a random stream.
module tb_ham_dec_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        err_corr, err_uncorr;
  logic [16:0] codeword_in;
  logic [11:0] info_out;
`ifdef HAM_DEC_ERRCNT_EN
  logic [15:0] corr_cnt, uncorr_cnt;
  logic        cnt_clr;
`endif

  always #5 clk = ~clk;

  ham_dec_pipe #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .codeword_in (codeword_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .info_out    (info_out),
    .err_corr    (err_corr),
`ifdef HAM_DEC_ERRCNT_EN
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt),
    .cnt_clr     (cnt_clr),
`endif
    .err_uncorr  (err_uncorr)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_popped = 0;
  logic [13:0] sb_q[$];
  logic [13:0] cur_exp;
  logic        acc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference encoder: info fills non-power-of-two positions in order.
  function automatic logic [16:0] ref_enc(input logic [11:0] info);
    logic [16:0] cw;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = info[j];
        j++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 17; p++) begin
        if (((p >> k) & 1) == 1 && p != (1 << k)) par = par ^ cw[p-1];
      end
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

  // Reference decoder: returns {info, corr, uncorr}.
  function automatic logic [13:0] ref_dec(input logic [16:0] cw_in);
    logic [16:0] cw;
    logic [11:0] info;
    int          s, j;
    cw = cw_in;
    s  = 0;
    for (int k = 0; k < 5; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 17; p++) if (((p >> k) & 1) == 1) par = par ^ cw[p-1];
      if (par) s = s | (1 << k);
    end
    if (s >= 1 && s <= 17) cw[s-1] = ~cw[s-1];
    info = '0;
    j    = 0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        info[j] = cw[p-1];
        j++;
      end
    end
    return {info, (s >= 1 && s <= 17), (s >= 18)};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_extra", out_valid, 0);
      end else begin
        logic [13:0] e;
        e = sb_q.pop_front();
        check_eq("info", info_out, e[13:2]);
        check_eq("flags", {err_corr, err_uncorr}, e[1:0]);
        n_popped++;
      end
      check_eq("excl", err_corr & err_uncorr, 0);
    end
  end

  task automatic step();
    @(negedge clk);
    acc = !rst && in_valid && in_ready;
    if (acc) sb_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send_cw(input logic [16:0] cw, input logic [13:0] exp, output int tries);
    codeword_in = cw;
    cur_exp     = exp;
    in_valid    = 1'b1;
    tries       = 0;
    acc         = 1'b0;
    while (!acc && tries < 40) begin
      step();
      tries++;
    end
    if (!acc) check_eq("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    step();
    check_eq("drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [16:0] w[3];
  logic [13:0] e[3];
  int          tries, idx, base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; codeword_in = '0; cur_exp = '0;
`ifdef HAM_DEC_ERRCNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("rst_ov", out_valid, 0);
    check_eq("rst_info", info_out, 0);
    check_eq("rst_flags", {err_corr, err_uncorr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean zero word, with latency check
    send_cw(17'h00000, {12'h000, 2'b00}, tries);
    @(negedge clk);
    check_eq("lat_s1", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("lat_s2", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Directed syndromes 3, 17, 18 back to back at full rate
    send_cw(17'h00004, {12'h000, 2'b10}, tries);
    check_eq("thru0", tries, 1);
    send_cw(17'h10000, {12'h000, 2'b10}, tries);
    check_eq("thru1", tries, 1);
    send_cw(17'h08002, {12'h000, 2'b01}, tries);
    check_eq("thru2", tries, 1);
    send_cw(ref_enc(12'hFFF), {12'hFFF, 2'b00}, tries);
    send_cw(ref_enc(12'h800) ^ 17'h10000, {12'h800, 2'b10}, tries);
    drain();

    // Backpressure: two words stored, third refused, outputs hold
    w[0] = ref_enc(12'hA5C);            e[0] = {12'hA5C, 2'b00};
    w[1] = ref_enc(12'h3F0) ^ 17'h00020; e[1] = {12'h3F0, 2'b10};
    w[2] = ref_enc(12'h001) ^ 17'h00080; e[2] = {12'h001, 2'b10};
    base = n_popped;
    out_ready = 1'b0;
    idx = 0;
    codeword_in = w[0]; cur_exp = e[0]; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("stall_rdy", in_ready, (idx < 2));
      if (c >= 2) check_eq("stall_out", {out_valid, info_out, err_corr, err_uncorr}, {1'b1, e[0]});
      acc = in_ready;
      if (acc) sb_q.push_back(cur_exp);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        codeword_in = w[idx]; cur_exp = e[idx];
      end
    end
    out_ready = 1'b1;
    send_cw(w[2], e[2], tries);
    drain();
    check_eq("stall_cnt", n_popped - base, 3);

    // Reset with two words in flight
    out_ready = 1'b0;
    send_cw(ref_enc(12'h123), {12'h123, 2'b00}, tries);
    send_cw(ref_enc(12'h456), {12'h456, 2'b00}, tries);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_eq("mrst_ov", out_valid, 0);
    check_eq("mrst_rdy", in_ready, 1);
`ifdef HAM_DEC_ERRCNT_EN
    check_eq("mrst_cnt", {corr_cnt, uncorr_cnt}, 0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_cw(ref_enc(12'h789), {12'h789, 2'b00}, tries);
    @(negedge clk);
    check_eq("post_s1", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("post_s2", out_valid, 1);
    @(posedge clk); #1;
    drain();

`ifdef HAM_DEC_ERRCNT_EN
    for (int i = 0; i < 3; i++) send_cw(ref_enc(12'h0F0) ^ (17'h1 << (i * 5)), {12'h0F0, 2'b10}, tries);
    drain();
    check_eq("corr_cnt3", corr_cnt, 3);
    check_eq("uncorr_cnt0", uncorr_cnt, 0);
    send_cw(17'h08002, {12'h000, 2'b01}, tries);
    drain();
    check_eq("uncorr_cnt1", uncorr_cnt, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_cnt", {corr_cnt, uncorr_cnt}, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_cw(17'h00004, {12'h000, 2'b10}, tries);
    step();
    cnt_clr = 1'b1; out_ready = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_wins", corr_cnt, 0);
    @(posedge clk); #1;
    drain();
`endif

    // Random stream with random backpressure and 0/1/2 bit errors
    base = n_popped;
    for (int n = 0; n < 40; n++) begin
      logic [11:0] inf;
      logic [16:0] cw;
      int          et, a, b;
      inf = 12'($urandom);
      cw  = ref_enc(inf);
      et  = $urandom_range(0, 2);
      a   = $urandom_range(0, 16);
      b   = (a + $urandom_range(1, 16)) % 17;
      if (et == 0) cur_exp = {inf, 2'b00};
      else if (et == 1) begin cw[a] = ~cw[a]; cur_exp = {inf, 2'b10}; end
      else begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; cur_exp = ref_dec(cw); end
      codeword_in = cw; in_valid = 1'b1;
      tries = 0; acc = 1'b0;
      while (!acc && tries < 40) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
        tries++;
      end
      if (!acc) check_eq("rnd_timeout", in_ready, 1);
      in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    check_eq("rnd_cnt", n_popped - base, 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
